// File: rtl/osecpu_prog_loader_if.sv
// Byte-stream input and program-memory write port of the OSECPU program loader.
// The master side is the host byte source plus memory; the slave side is the loader.
interface osecpu_prog_loader_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_we;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/osecpu_prog_loader.sv
// Loads a length-prefixed big-endian program image into program memory and holds the core in reset until done.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module osecpu_prog_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    osecpu_prog_loader_if.slave  bus,
    output logic                 cpu_reset,
    output logic                 done,
    output logic                 error,
    output logic [15:0]          words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_FINISH,
        S_DONE,
        S_ERROR
`ifdef LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t                state_reg;
    logic                  in_ready_reg;
    logic                  mem_we_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [31:0]           mem_wdata_reg;
    logic                  cpu_reset_reg;
    logic                  done_reg;
    logic                  error_reg;
    logic [15:0]           words_loaded_reg;
    logic [15:0]           len_reg;
    logic [31:0]           asm_reg;
    logic [1:0]            byte_idx_reg;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            xor_reg;
`endif

    logic        handshake;
    logic [15:0] len_assembled;
    logic [31:0] word_assembled;
    logic [15:0] words_inc;

    assign handshake      = bus.in_valid && in_ready_reg;
    assign len_assembled  = {len_reg[15:8], bus.in_data};
    assign word_assembled = {asm_reg[23:0], bus.in_data};
    assign words_inc      = words_loaded_reg + 16'd1;

    // in_ready is registered, so every transition sets it for the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            in_ready_reg     <= 1'b0;
            mem_we_reg       <= 1'b0;
            mem_addr_reg     <= ADDR_WIDTH'(BASE_ADDR);
            mem_wdata_reg    <= 32'd0;
            cpu_reset_reg    <= 1'b1;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
            words_loaded_reg <= 16'd0;
            len_reg          <= 16'd0;
            asm_reg          <= 32'd0;
            byte_idx_reg     <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            xor_reg          <= 8'd0;
`endif
        end else begin
            mem_we_reg <= 1'b0;
            done_reg   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            if (handshake && state_reg != S_CHK)
                xor_reg <= xor_reg ^ bus.in_data;
`endif
            case (state_reg)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_reg        <= S_LEN_HI;
                        in_ready_reg     <= 1'b1;
                        cpu_reset_reg    <= 1'b1;
                        error_reg        <= 1'b0;
                        words_loaded_reg <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
                        xor_reg          <= 8'd0;
`endif
                    end
                end
                S_LEN_HI: begin
                    if (handshake) begin
                        len_reg[15:8] <= bus.in_data;
                        state_reg     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (handshake) begin
                        len_reg <= len_assembled;
                        if (len_assembled == 16'd0) begin
                            state_reg    <= S_FINISH;
                            in_ready_reg <= 1'b0;
                            done_reg     <= 1'b1;
                        end else if (32'(len_assembled) > MAX_WORDS) begin
                            state_reg    <= S_ERROR;
                            in_ready_reg <= 1'b0;
                            error_reg    <= 1'b1;
                        end else begin
                            state_reg    <= S_DATA;
                            byte_idx_reg <= 2'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (handshake) begin
                        asm_reg      <= word_assembled;
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            state_reg     <= S_WRITE;
                            in_ready_reg  <= 1'b0;
                            mem_we_reg    <= 1'b1;
                            mem_wdata_reg <= word_assembled;
                            // Address wraps modulo 2**ADDR_WIDTH by truncation.
                            mem_addr_reg  <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(words_loaded_reg);
                        end
                    end
                end
                S_WRITE: begin
                    words_loaded_reg <= words_inc;
                    if (words_inc == len_reg) begin
`ifdef LOADER_CHECKSUM_EN
                        state_reg    <= S_CHK;
                        in_ready_reg <= 1'b1;
`else
                        state_reg    <= S_FINISH;
                        done_reg     <= 1'b1;
`endif
                    end else begin
                        state_reg    <= S_DATA;
                        in_ready_reg <= 1'b1;
                        byte_idx_reg <= 2'd0;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (handshake) begin
                        in_ready_reg <= 1'b0;
                        if (bus.in_data == xor_reg) begin
                            state_reg <= S_FINISH;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_ERROR;
                            error_reg <= 1'b1;
                        end
                    end
                end
`endif
                S_FINISH: begin
                    cpu_reset_reg <= 1'b0;
                    state_reg     <= S_DONE;
                end
                default: begin
                    state_reg    <= S_IDLE;
                    in_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign cpu_reset     = cpu_reset_reg;
    assign done          = done_reg;
    assign error         = error_reg;
    assign words_loaded  = words_loaded_reg;

endmodule
